// File: rtl/hex_display_pkg.sv
// Shared types, segment constants and the leading-zero helper for the
// six-digit hex display controller.
package hex_display_pkg;

    typedef enum logic {
        PAGE_LO = 1'b0,
        PAGE_HI = 1'b1
    } page_t;

    localparam int         NUM_DIGITS = 6;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_H      = 7'b0001001;
    localparam logic [6:0] SEG_ZERO   = 7'b1000000;

    // Bit i is set when digit i sits above the most significant non-zero
    // nibble of the low 24 bits. Digit 0 is never marked, so zero shows "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [23:0] v);
        logic [NUM_DIGITS-1:0] m;
        m = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if ((v >> (4 * i)) == 24'd0) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// Hex nibble to active-low 7-segment decoder (bit6=g .. bit0=a).
module seg7_hex (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure lookup from nibble to segment pattern.
    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Six-digit 7-segment display controller. Latches a 32-bit value and,
// when the top byte is non-zero, alternates a low page (bits 23:0) and a
// high page (bits 31:24 plus an "H" marker) every PAGE_CYCLES clocks.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// on the low page when paging is off.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int PAGE_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        hold,
    output logic        page,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int             CW       = $clog2(PAGE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PAGE_CYCLES - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_RST_UPPER = SEG_BLANK;
`else
    localparam logic [6:0] SEG_RST_UPPER = SEG_ZERO;
`endif

    logic [31:0]   value_q, value_d;
    page_t         page_q, page_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          paging_en;

    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0][6:0] seg_dec;
    logic [NUM_DIGITS-1:0][6:0] seg_d;
    logic [NUM_DIGITS-1:0][6:0] hex_q;

    assign paging_en = |value_q[31:24];

    // Next-state: a write wins over everything, then paging-off forces the
    // low page, otherwise the page timer runs unless held.
    always_comb begin
        value_d = value_q;
        page_d  = page_q;
        cnt_d   = cnt_q;
        if (wr_en) begin
            value_d = wr_data;
            page_d  = PAGE_LO;
            cnt_d   = '0;
        end else if (!paging_en) begin
            page_d  = PAGE_LO;
            cnt_d   = '0;
        end else if (!hold) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                page_d = (page_q == PAGE_LO) ? PAGE_HI : PAGE_LO;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    // Value, page and timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            page_q  <= PAGE_LO;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            page_q  <= page_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select which nibble each digit decodes; the high page shows the top
    // byte on the two lowest digits.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib[i] = value_q[4*i +: 4];
        end
        if (page_q == PAGE_HI) begin
            nib[0] = value_q[27:24];
            nib[1] = value_q[31:28];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_hex u_seg7_hex (
            .nibble_i (nib[g]),
            .seg_o    (seg_dec[g])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask;
    assign blank_mask = lead_zero_mask(value_q[23:0]);
`endif

    // Override decoded digits with blanks and the "H" marker.
    always_comb begin
        seg_d = seg_dec;
        if (page_q == PAGE_HI) begin
            seg_d[2] = SEG_BLANK;
            seg_d[3] = SEG_BLANK;
            seg_d[4] = SEG_BLANK;
            seg_d[5] = SEG_H;
        end
`ifdef LEADING_ZERO_BLANK_EN
        else if (!paging_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (blank_mask[i]) begin
                    seg_d[i] = SEG_BLANK;
                end
            end
        end
`endif
    end

    // Output segment registers, one cycle behind value and page.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_q[0] <= SEG_ZERO;
            for (int i = 1; i < NUM_DIGITS; i++) begin
                hex_q[i] <= SEG_RST_UPPER;
            end
        end else begin
            hex_q <= seg_d;
        end
    end

    assign page = page_q;
    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl with a behavioural display model.
module tb_hex_display_ctrl;

    localparam int PC = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        hold = 1'b0;
    logic        page;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    hex_display_ctrl #(.PAGE_CYCLES(PC)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .hold    (hold),
        .page    (page),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3),
        .hex4    (hex4),
        .hex5    (hex5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pg;
        logic [41:0] hex;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    logic [31:0] mVal  = '0;
    bit          mPage = 1'b0;
    int          mCnt  = 0;

    logic [6:0] segTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // What the display should show for a stored value and page.
    function automatic logic [41:0] expectDigits(input logic [31:0] v, input bit pg);
        logic [41:0] r;
        int top;
        r = '0;
        if (pg) begin
            r[6:0]   = segTab[v[27:24]];
            r[13:7]  = segTab[v[31:28]];
            r[20:14] = 7'h7F;
            r[27:21] = 7'h7F;
            r[34:28] = 7'h7F;
            r[41:35] = 7'b0001001;
        end else begin
            for (int i = 0; i < 6; i++) r[7*i +: 7] = segTab[v[4*i +: 4]];
            if (LZB && v[31:24] == 8'd0) begin
                top = 0;
                for (int i = 0; i < 6; i++) if (v[4*i +: 4] != 4'd0) top = i;
                for (int i = 1; i < 6; i++) if (i > top) r[7*i +: 7] = 7'h7F;
            end
        end
        return r;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge and queue
    // the outputs the DUT should show after that edge.
    task automatic applyStimulus(input bit rst, input bit wr, input logic [31:0] data, input bit hd);
        exp_t e;
        reset   = rst;
        wr_en   = wr;
        wr_data = data;
        hold    = hd;
        @(posedge clk);
        if (rst) begin
            e.hex = LZB ? {{5{7'h7F}}, 7'b1000000} : {6{7'b1000000}};
            mVal  = '0;
            mPage = 1'b0;
            mCnt  = 0;
        end else begin
            e.hex = expectDigits(mVal, mPage);
            if (wr) begin
                mVal  = data;
                mPage = 1'b0;
                mCnt  = 0;
            end else if (mVal[31:24] == 8'd0) begin
                mPage = 1'b0;
                mCnt  = 0;
            end else if (!hd) begin
                if (mCnt == PC - 1) begin
                    mCnt  = 0;
                    mPage = ~mPage;
                end else begin
                    mCnt = mCnt + 1;
                end
            end
        end
        e.pg = mPage;
        expQ.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [41:0] act;
        act = {hex5, hex4, hex3, hex2, hex1, hex0};
        assertCount++;
        if (page !== e.pg) begin
            failCount++;
            $display("[TB] FAIL page: got %b expected %b at %0t", page, e.pg, $time);
        end
        assertCount++;
        if (act !== e.hex) begin
            failCount++;
            $display("[TB] FAIL hex5..hex0: got %h expected %h at %0t", act, e.hex, $time);
        end
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int guard;
        logic [31:0] d;

        // Reset and idle.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        idle(3);

        // No paging value.
        applyStimulus(1'b0, 1'b1, 32'h00ABCDEF, 1'b0);
        idle(20);

        // Paging value, reach the high page.
        applyStimulus(1'b0, 1'b1, 32'h12345678, 1'b0);
        idle(6);

        // Hold on the high page, then release.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        idle(8);

        // Write zero on the edge where the timer would wrap.
        guard = 0;
        while (mCnt != PC - 1 && guard < 20) begin
            idle(1);
            guard++;
        end
        applyStimulus(1'b0, 1'b1, 32'h00000000, 1'b0);
        idle(3);

        // Reset with a write while on the high page.
        applyStimulus(1'b0, 1'b1, 32'h12345678, 1'b0);
        guard = 0;
        while (!mPage && guard < 20) begin
            idle(1);
            guard++;
        end
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 0) d[31:24] = 8'h00;
            if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(1, 6));
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                          d, $urandom_range(0, 3) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Display controller that latches a 32-bit value written by the hart and drives six active-low 7-segment digits (HEX0..HEX5).
Six digits show 24 bits. When the top byte is non-zero, the controller alternates between a low page and a high page on a timer.
Each digit's nibble is decoded by the existing seg7_hex decoder. The controller overrides the decoder output with blank or marker patterns, then registers the final segment values.

Parameters:
PAGE_CYCLES, 50_000_000, clock cycles each page is shown (1 s at 50 MHz); legal range is 2 or more.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
wr_en  input  1  write strobe; wr_data is captured on the edge where wr_en=1.
wr_data  input  32  value to display.
hold  input  1  when 1, freezes the page timer and the current page.
page  output  1  current page: 0 = LO, 1 = HI; registered.
hex0..hex5  output  7 each  active-low segment patterns (bit6=g .. bit0=a); registered.

Behaviour:
- State is value_q[31:0], page FSM {PAGE_LO, PAGE_HI} and cnt (width $clog2(PAGE_CYCLES)).
- Reset values: value_q=0, page=PAGE_LO, cnt=0.
  - hex0..hex5 = 7'b1000000 ("0") on the edge where reset=1.
  - With LEADING_ZERO_BLANK_EN: hex1..hex5 = 7'h7F instead.
- Reset dominates wr_en and hold.
- Write: on an edge with wr_en=1, set value_q=wr_data, page=PAGE_LO, cnt=0. This applies regardless of hold and regardless of the current page.
- Paging enable: paging is enabled when value_q[31:24] != 0.
  - If not enabled, force page to PAGE_LO and cnt to 0.
- Timer: when paging is enabled and hold=0 and wr_en=0:
  - If cnt == PAGE_CYCLES-1: cnt=0 and page toggles.
  - Otherwise cnt increments.
  - With hold=1, cnt and page are unchanged.
- PAGE_LO output: hexN shows nibble value_q[4N+3:4N], N=0..5.
- PAGE_HI output:
  - hex0 = value_q[27:24], hex1 = value_q[31:28].
  - hex2..hex4 = 7'h7F (blank).
  - hex5 = SEG_H = 7'b0001001 (letter H).
- Latency:
  - page is registered and changes on the same edge as cnt wraps or a write occurs.
  - hexN is registered from the decoded value_q/page, so it lags page and value_q by exactly 1 cycle.
  - Write sampled at edge k → new digits visible after edge k+1.
- Simultaneous events: a write on the same edge as a timer wrap behaves as a write only (page=PAGE_LO, cnt=0).
- No output ever holds X after the first reset edge.

Optional Feature:
LEADING_ZERO_BLANK_EN.
- Defined:
  - In PAGE_LO with value_q[31:24]==0, digits above the most significant non-zero nibble show 7'h7F.
  - hex0 is never blanked; a value of 0 shows a single "0".
  - When paging is enabled, no blanking is applied, because all low-page zeros are significant.
- Undefined: all six digits are always shown in PAGE_LO.
- PAGE_HI behaviour is identical in both builds.

Decomposition:
- Package hex_display_pkg holds:
  - page_t enum {PAGE_LO, PAGE_HI}
  - SEG_BLANK = 7'h7F
  - SEG_H = 7'b0001001
  - NUM_DIGITS = 6
- Sub-modules: six instances of seg7_hex, one per digit, fed by the page-muxed nibble.
- The leading-zero mask is a small combinational function inside the package.

Test Plan:
1. Apply reset, then idle 3 cycles → page=0, hex0..hex5 = 7'b1000000 (with the macro: hex0 = 7'b1000000, hex1..5 = 7'h7F).
2. PAGE_CYCLES=4; write 32'h00ABCDEF → after 2 edges: hex5..hex0 = A,b,C,d,E,F (7'b0001000, 0000011, 1000110, 0100001, 0000110, 0001110); page stays 0 for 20 cycles.
3. PAGE_CYCLES=4; write 32'h12345678 → page=0 for 4 cycles, then 1 for 4 cycles, repeating.
   - On PAGE_HI: hex1="1" 7'b1111001, hex0="2" 7'b0100100, hex2..4=7'h7F, hex5=7'b0001001.
4. While in PAGE_HI, raise hold for 10 cycles → page and hex unchanged. Drop hold → toggles after 4 more cycles.
5. Write 32'h00000000 on the same edge the cnt wrap would occur → page=0, cnt=0, all digits "0" (macro: only hex0 lit).
6. Assert reset mid-PAGE_HI together with wr_en=1 → next edge: value_q=0, page=0; wr_data is ignored.
